// File: rtl/data_mem_access_unit.sv
// Load/store unit between the MEM stage and the word-organised Data_RAM.
// Handles little-endian sub-word lane selection, sign/zero extension and read-modify-write stores.
module data_mem_access_unit #(
   parameter int unsigned RAM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [1:0]  i_size,
   input  logic        i_sign,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_data,
   output logic [31:0] o_data,
   output logic        o_done,
   output logic        o_err,
   output logic        o_busy,
   output logic [31:0] o_ram_addr,
   output logic [31:0] o_ram_data,
   output logic        o_ram_we,
   input  logic [31:0] i_ram_data
);

   typedef enum logic [2:0] {IDLE, RD, RMW, WR, DONE, ERR} state_t;

   localparam logic [31:0] ADDR_LIMIT = 32'(RAM_WORDS * 4);

   state_t      state_q, state_d;
   logic [1:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic [1:0]  lane_q, lane_d;
   logic [15:0] dataLow_q, dataLow_d;
   logic [31:0] ramAddr_q, ramAddr_d;
   logic [31:0] ramData_q, ramData_d;
   logic [31:0] loadData_q, loadData_d;

   logic        reqBad;
   logic [7:0]  laneByte;
   logic [15:0] laneHalf;
   logic [31:0] loadExt;
   logic [31:0] merged;

   assign reqBad = (i_size == 2'b11)
                 || ((i_size == 2'b01) && i_addr[0])
                 || ((i_size == 2'b10) && (i_addr[1:0] != 2'b00))
                 || (i_addr >= ADDR_LIMIT);

   always_comb begin
      laneByte = i_ram_data[{lane_q, 3'b000} +: 8];
      laneHalf = lane_q[1] ? i_ram_data[31:16] : i_ram_data[15:0];
      case (size_q)
         2'b00:   loadExt = {{24{sign_q & laneByte[7]}}, laneByte};
         2'b01:   loadExt = {{16{sign_q & laneHalf[15]}}, laneHalf};
         default: loadExt = i_ram_data;
      endcase
   end

   // Sub-word store: overwrite only the addressed lane of the word just read.
   always_comb begin
      merged = i_ram_data;
      if (size_q == 2'b00) begin
         merged[{lane_q, 3'b000} +: 8] = dataLow_q[7:0];
      end else if (lane_q[1]) begin
         merged[31:16] = dataLow_q;
      end else begin
         merged[15:0] = dataLow_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      size_d     = size_q;
      sign_d     = sign_q;
      lane_d     = lane_q;
      dataLow_d  = dataLow_q;
      ramAddr_d  = ramAddr_q;
      ramData_d  = ramData_q;
      loadData_d = loadData_q;
      case (state_q)
         IDLE: begin
            if (i_req) begin
               size_d    = i_size;
               sign_d    = i_sign;
               lane_d    = i_addr[1:0];
               dataLow_d = i_data[15:0];
               if (reqBad) begin
                  state_d = ERR;
               end else begin
                  ramAddr_d = {2'b00, i_addr[31:2]};
                  if (!i_we) begin
                     state_d = RD;
                  end else if (i_size == 2'b10) begin
                     ramData_d = i_data;
                     state_d   = WR;
                  end else begin
                     state_d = RMW;
                  end
               end
            end
         end
         RD: begin
            loadData_d = loadExt;
            state_d    = DONE;
         end
         RMW: begin
            ramData_d = merged;
            state_d   = WR;
         end
         WR:      state_d = DONE;
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         size_q     <= 2'b00;
         sign_q     <= 1'b0;
         lane_q     <= 2'b00;
         dataLow_q  <= 16'h0000;
         ramAddr_q  <= 32'h0;
         ramData_q  <= 32'h0;
         loadData_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         size_q     <= size_d;
         sign_q     <= sign_d;
         lane_q     <= lane_d;
         dataLow_q  <= dataLow_d;
         ramAddr_q  <= ramAddr_d;
         ramData_q  <= ramData_d;
         loadData_q <= loadData_d;
      end
   end

   // Write enable is a pure state decode so reset kills an in-flight write immediately.
   assign o_ram_we   = (state_q == WR);
   assign o_done     = (state_q == DONE) || (state_q == ERR);
   assign o_err      = (state_q == ERR);
   assign o_busy     = (state_q != IDLE);
   assign o_data     = loadData_q;
   assign o_ram_addr = ramAddr_q;
   assign o_ram_data = ramData_q;

endmodule
